// File: rtl/muldiv_pkg.sv
// Shared types and constants for the HI/LO multiply/divide sequencer.
package muldiv_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [3:0] {
      MD_NONE  = 4'd0,
      MD_MULT  = 4'd1,
      MD_MULTU = 4'd2,
      MD_DIV   = 4'd3,
      MD_DIVU  = 4'd4,
      MD_MADD  = 4'd5,
      MD_MADDU = 4'd6,
      MD_MSUB  = 4'd7,
      MD_MSUBU = 4'd8
   } muldiv_op_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MUL  = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } muldiv_state_t;

   localparam int DIV_ITERS = 32;

   // Low 64 bits of the product of the extended operands equal the exact
   // signed (sgn=1) or unsigned (sgn=0) 32x32 product.
   function automatic logic [63:0] mul64(input word_t x, input word_t y, input logic sgn);
      logic [63:0] xe;
      logic [63:0] ye;
      xe = {{32{sgn & x[31]}}, x};
      ye = {{32{sgn & y[31]}}, y};
      return xe * ye;
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath: one quotient bit per step, sign fix on the outputs.
module muldiv_div_core
   import muldiv_pkg::*;
(
   input  logic  clk,
   input  logic  reset,
   input  logic  load,
   input  logic  step,
   input  logic  is_signed,
   input  word_t dividend,
   input  word_t divisor,
   output word_t quo_fixed,
   output word_t rem_fixed
);

   word_t       rem_reg;
   word_t       quo_reg;
   word_t       dvs_reg;
   logic        neg_q_reg;
   logic        neg_r_reg;

   logic [32:0] shifted;
   logic [32:0] trial;
   logic        fits;
   word_t       rem_next;
   word_t       quo_next;
   logic        neg_a;
   logic        neg_b;

   assign neg_a = is_signed & dividend[31];
   assign neg_b = is_signed & divisor[31];

   // Outputs already include the step in progress so the final one can be
   // captured by the sequencer on the same edge that completes it.
   always_comb begin
      shifted   = {rem_reg, quo_reg[31]};
      trial     = shifted - {1'b0, dvs_reg};
      fits      = ~trial[32];
      rem_next  = fits ? trial[31:0] : shifted[31:0];
      quo_next  = {quo_reg[30:0], fits};
      quo_fixed = neg_q_reg ? (~quo_next + 32'd1) : quo_next;
      rem_fixed = neg_r_reg ? (~rem_next + 32'd1) : rem_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_reg   <= '0;
         quo_reg   <= '0;
         dvs_reg   <= '0;
         neg_q_reg <= 1'b0;
         neg_r_reg <= 1'b0;
      end else if (load) begin
         rem_reg   <= '0;
         quo_reg   <= neg_a ? (~dividend + 32'd1) : dividend;
         dvs_reg   <= neg_b ? (~divisor + 32'd1) : divisor;
         neg_q_reg <= neg_a ^ neg_b;
         neg_r_reg <= neg_a;
      end else if (step) begin
         rem_reg <= rem_next;
         quo_reg <= quo_next;
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/DIV sequencer driving stall and a one-cycle HI/LO write.
// Define MULDIV_MADD_EN to accept MADD/MADDU/MSUB/MSUBU.
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int MUL_LAT = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  muldiv_op_t op,
   input  word_t      a,
   input  word_t      b,
   input  word_t      hi_in,
   input  word_t      lo_in,
   input  logic       cancel,
   output logic       stall,
   output logic       valid,
   output word_t      hi,
   output word_t      lo
);

   muldiv_state_t state;
   logic [4:0]    count;
   logic [63:0]   mul_res;

   logic          accept_mul;
   logic          accept_div;
   logic          go;
   logic          mul_signed;
   logic [63:0]   prod;
   logic [63:0]   mul_next;
   word_t         quo_fixed;
   word_t         rem_fixed;

`ifdef MULDIV_MADD_EN
   always_comb begin
      accept_mul = (op == MD_MULT) || (op == MD_MULTU) || (op == MD_MADD) ||
                   (op == MD_MADDU) || (op == MD_MSUB) || (op == MD_MSUBU);
      mul_signed = (op == MD_MULT) || (op == MD_MADD) || (op == MD_MSUB);
      prod       = mul64(a, b, mul_signed);
      // Accumulator is sampled together with the operands, so the whole
      // 64-bit result is settled before entering MUL.
      case (op)
         MD_MADD, MD_MADDU: mul_next = {hi_in, lo_in} + prod;
         MD_MSUB, MD_MSUBU: mul_next = {hi_in, lo_in} - prod;
         default:           mul_next = prod;
      endcase
   end
`else
   logic unused_acc;
   assign unused_acc = ^{hi_in, lo_in};

   always_comb begin
      accept_mul = (op == MD_MULT) || (op == MD_MULTU);
      mul_signed = (op == MD_MULT);
      prod       = mul64(a, b, mul_signed);
      mul_next   = prod;
   end
`endif

   assign accept_div = (op == MD_DIV) || (op == MD_DIVU);
   assign go         = (state == ST_IDLE) && start && !cancel && (accept_mul || accept_div);
   assign stall      = go || (state == ST_MUL) || (state == ST_DIV);
   assign valid      = (state == ST_DONE) && !cancel;

   muldiv_div_core u_div (
      .clk       (clk),
      .reset     (reset),
      .load      (go && accept_div),
      .step      (state == ST_DIV),
      .is_signed (op == MD_DIV),
      .dividend  (a),
      .divisor   (b),
      .quo_fixed (quo_fixed),
      .rem_fixed (rem_fixed)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         count   <= '0;
         mul_res <= '0;
         hi      <= '0;
         lo      <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (go) begin
                  if (accept_div) begin
                     count <= 5'(DIV_ITERS - 1);
                     state <= ST_DIV;
                  end else begin
                     mul_res <= mul_next;
                     count   <= 5'(MUL_LAT - 1);
                     state   <= ST_MUL;
                  end
               end
            end
            ST_MUL: begin
               if (cancel) begin
                  state <= ST_IDLE;
               end else if (count == 5'd0) begin
                  hi    <= mul_res[63:32];
                  lo    <= mul_res[31:0];
                  state <= ST_DONE;
               end else begin
                  count <= count - 5'd1;
               end
            end
            ST_DIV: begin
               if (cancel) begin
                  state <= ST_IDLE;
               end else if (count == 5'd0) begin
                  hi    <= rem_fixed;
                  lo    <= quo_fixed;
                  state <= ST_DONE;
               end else begin
                  count <= count - 5'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Randomized self-checking bench for muldiv_seq against an arithmetic reference model.
module tb_muldiv_seq;
   import muldiv_pkg::*;

   localparam int MUL_LAT = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   muldiv_op_t op = MD_NONE;
   word_t      a = '0;
   word_t      b = '0;
   word_t      hi_in = '0;
   word_t      lo_in = '0;
   logic       cancel = 1'b0;
   logic       stall;
   logic       valid;
   word_t      hi;
   word_t      lo;

   int n_cmp = 0;
   int n_bad = 0;

   muldiv_seq #(.MUL_LAT(MUL_LAT)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .hi_in  (hi_in),
      .lo_in  (lo_in),
      .cancel (cancel),
      .stall  (stall),
      .valid  (valid),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected HI/LO, acceptance and valid cycle from the arithmetic rules.
   function automatic void model(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                                 input logic [31:0] ih, input logic [31:0] il,
                                 output logic [31:0] eh, output logic [31:0] el,
                                 output bit acc, output int lat);
      int sx;
      int sy;
      logic [63:0] r;
      sx  = x;
      sy  = y;
      acc = 1'b1;
      lat = MUL_LAT + 1;
      r   = '0;
      eh  = '0;
      el  = '0;
      case (o)
         MD_MULT:  r = longint'(sx) * longint'(sy);
         MD_MULTU: r = {32'd0, x} * {32'd0, y};
`ifdef MULDIV_MADD_EN
         MD_MADD:  r = {ih, il} + 64'(longint'(sx) * longint'(sy));
         MD_MADDU: r = {ih, il} + {32'd0, x} * {32'd0, y};
         MD_MSUB:  r = {ih, il} - 64'(longint'(sx) * longint'(sy));
         MD_MSUBU: r = {ih, il} - {32'd0, x} * {32'd0, y};
`endif
         MD_DIV, MD_DIVU: lat = DIV_ITERS + 1;
         default: acc = 1'b0;
      endcase
      {eh, el} = r;
      if (o == MD_DIV) begin
         if (y == 0) begin
            eh = x;
            el = (sx < 0) ? 32'h1 : 32'hFFFF_FFFF;
         end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            el = x;
            eh = 0;
         end else begin
            el = sx / sy;
            eh = sx % sy;
         end
      end else if (o == MD_DIVU) begin
         if (y == 0) begin
            el = 32'hFFFF_FFFF;
            eh = x;
         end else begin
            el = x / y;
            eh = x % y;
         end
      end
   endfunction

   // Issue one op at cycle 0 and follow it cycle by cycle until it should be over.
   task automatic run_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] ih, input logic [31:0] il);
      logic [31:0] eh, el, gh, gl;
      bit acc;
      int lat;
      int vcyc;
      int pulses;
      int bad_stall;
      model(o, x, y, ih, il, eh, el, acc, lat);
      @(negedge clk);
      op = o; a = x; b = y; hi_in = ih; lo_in = il; start = 1'b1;
      #1 check("stall_c0", stall, acc);
      @(posedge clk);
      #1;
      start = 1'b0;
      op = MD_NONE;
      vcyc = -1; pulses = 0; bad_stall = 0; gh = '0; gl = '0;
      for (int k = 1; k <= lat + 2; k++) begin
         if (stall !== (acc && k < lat)) bad_stall++;
         if (valid === 1'b1) begin
            pulses++;
            if (vcyc < 0) begin
               vcyc = k; gh = hi; gl = lo;
            end
         end else if (valid !== 1'b0) begin
            pulses += 100;
         end
         @(posedge clk);
         #1;
      end
      check("stall_seq", bad_stall, 0);
      check("pulses", pulses, acc ? 1 : 0);
      if (acc) begin
         check("valid_cyc", vcyc, lat);
         check("hi", gh, eh);
         check("lo", gl, el);
      end
      $display("op=%s a=%h b=%h hi_in=%h lo_in=%h -> valid@%0d hi=%h lo=%h (exp hi=%h lo=%h)",
               o.name(), x, y, ih, il, vcyc, gh, gl, eh, el);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int pend;
      muldiv_op_t ro;
      logic [31:0] rx, ry;

      repeat (2) @(posedge clk);
      #1;
      check("rst_hi", hi, 0);
      check("rst_lo", lo, 0);
      check("rst_stall", stall, 0);
      check("rst_valid", valid, 0);
      @(negedge clk);
      reset = 1'b0;

      run_op(MD_MULT,  32'hFFFF_FFFE, 32'd3, 0, 0);
      run_op(MD_DIVU,  32'd100, 32'd7, 0, 0);
      run_op(MD_DIV,   32'hFFFF_FFF9, 32'd2, 0, 0);
      run_op(MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
      run_op(MD_DIVU,  32'd5, 32'd0, 0, 0);
      run_op(MD_DIV,   32'hFFFF_FFFB, 32'd0, 0, 0);

      // start together with cancel in IDLE is ignored
      @(negedge clk);
      op = MD_MULT; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
      #1 check("cxl_idle_stall", stall, 0);
      @(posedge clk);
      #1;
      start = 1'b0; cancel = 1'b0; op = MD_NONE;
      check("cxl_idle_after", stall, 0);

      // cancel a divide at cycle 10
      @(negedge clk);
      op = MD_DIV; a = 32'd1000; b = 32'd3; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = MD_NONE;
      repeat (9) @(posedge clk);
      #1;
      cancel = 1'b1;
      check("cxl_c10_stall", stall, 1);
      @(posedge clk);
      #1;
      cancel = 1'b0;
      check("cxl_c11_stall", stall, 0);
      pend = 0;
      for (int k = 0; k < 30; k++) begin
         if (valid !== 1'b0 || stall !== 1'b0) pend++;
         @(posedge clk);
         #1;
      end
      check("cxl_quiet", pend, 0);
      run_op(MD_MULTU, 32'd2, 32'd3, 0, 0);

      // asynchronous reset in the middle of a divide
      run_op(MD_MULT, 32'hFFFF_FFFE, 32'd3, 0, 0);
      @(negedge clk);
      op = MD_DIV; a = 32'd100; b = 32'd7; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0; op = MD_NONE;
      repeat (4) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      check("arst_stall", stall, 0);
      check("arst_valid", valid, 0);
      check("arst_hi", hi, 0);
      check("arst_lo", lo, 0);
      @(negedge clk);
      reset = 1'b0;

      run_op(MD_NONE,  32'd4, 32'd5, 0, 0);
      run_op(MD_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF);
      run_op(MD_MSUB,  32'hFFFF_FFFF, 32'd5, 32'd0, 32'd2);

      for (int i = 0; i < 40; i++) begin
         ro = muldiv_op_t'($urandom_range(0, 8));
         rx = $urandom;
         ry = $urandom;
         if ($urandom_range(0, 3) == 0) ry = $urandom_range(0, 15);
         if ($urandom_range(0, 7) == 0) ry = 32'd0;
         if ($urandom_range(0, 9) == 0) ry = 32'hFFFF_FFFF;
         run_op(ro, rx, ry, $urandom, $urandom);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
